// File: rtl/store_narrow_unit_pkg.sv
// Shared types for the store narrowing unit: access-size codes, FSM state
// encodings and the alignment rule used at request acceptance.
package store_narrow_unit_pkg;

  localparam int ADDR_W_DEF = 6;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_narrow_unit_if.sv
// Request handshake from the datapath plus the word-wide data RAM port.
// The slave modport is the store unit's view.
interface store_narrow_unit_if #(parameter int ADDR_W = 6);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_size;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              done;
  logic              misalign;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;

  modport slave (
    input  req_valid, req_size, req_addr, req_wdata, mem_rdata,
    output req_ready, done, misalign, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_size, req_addr, req_wdata, mem_rdata,
    input  req_ready, done, misalign, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/store_narrow_unit_merge.sv
// Little-endian lane insert: replaces the addressed byte/halfword of a word
// with the low bits of the store data; all other bits pass through.
module store_merge
  import store_narrow_unit_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] new_word_o
);

  always_comb begin
    new_word_o = old_word_i;
    case (size_i)
      SIZE_BYTE: new_word_o[{offset_i, 3'b000} +: 8]  = data_i[7:0];
      SIZE_HALF: new_word_o[{offset_i[1], 4'b0000} +: 16] = data_i[15:0];
      SIZE_WORD: new_word_o = data_i;
      default:   new_word_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Narrows SB/SH/SW stores onto a word-addressed RAM; sub-word stores do a
// read-modify-write, misaligned or illegal-size requests are rejected.
//
//   state | meaning
//   IDLE  | ready for a request
//   READ  | mem_re issued for the target word
//   MERGE | RAM data valid, merged word registered
//   WRITE | mem_we with full word, done pulse
//   ERR   | rejected request, done + misalign pulse
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  store_narrow_unit_if.slave   bus
);

  state_e             state_q, state_d;
  logic [1:0]         size_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        merged_q, merged_d;
  logic               accept;
  logic               unused_addr_bits;

  // Addresses wrap modulo memory size, so high address bits are dropped.
  assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

  assign accept = (state_q == ST_IDLE) && bus.req_valid;

  store_merge u_merge (
    .old_word_i (bus.mem_rdata),
    .data_i     (wdata_q),
    .size_i     (size_q),
    .offset_i   (addr_q[1:0]),
    .new_word_o (merged_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr[ADDR_W+1:0];
        wdata_q <= bus.req_wdata;
      end
      if (state_q == ST_MERGE) merged_q <= merged_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (is_misaligned(bus.req_size, bus.req_addr[1:0])) state_d = ST_ERR;
          else if (bus.req_size == SIZE_WORD)                 state_d = ST_WRITE;
          else                                                state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_MERGE;
      ST_MERGE: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE) && !rst;
  assign bus.done      = (state_q == ST_WRITE) || (state_q == ST_ERR);
  assign bus.misalign  = (state_q == ST_ERR);
  assign bus.mem_re    = (state_q == ST_READ);
  assign bus.mem_we    = (state_q == ST_WRITE);
  assign bus.mem_addr  = addr_q[ADDR_W+1:2];
  assign bus.mem_wdata = (size_q == SIZE_WORD) ? wdata_q : merged_q;

endmodule
